uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Command-frame controller that consumes the byte stream produced by the UART receiver (parallel byte + valid pulse) and drives the UART transmitter's parallel input. It decodes write and read frames into register-file accesses. It returns read data, or an error code on read timeout, as a single byte to the transmitter. It sits between the UART and the register file in the system controller path.

Parameters:
DATA_WIDTH, 8, width of UART bytes and register data
ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte
WR_CMD, 8'hAA, command byte opening a write frame (cmd, addr, data)
RD_CMD, 8'hBB, command byte opening a read frame (cmd, addr)
RD_TIMEOUT, 15, cycles to wait for RF_RdData_VLD before replying with TO_CODE
TO_CODE, 8'hFF, byte sent when a read times out

Ports:
CLK  input  1  single clock
RST  input  1  asynchronous, active-high reset
RX_P_DATA  input  DATA_WIDTH  received byte
RX_D_VLD  input  1  one-cycle strobe; RX_P_DATA is valid this cycle
TX_BUSY  input  1  transmitter busy; high while a frame is being shifted out
RF_RdData  input  DATA_WIDTH  register-file read data
RF_RdData_VLD  input  1  one-cycle strobe; RF_RdData is valid this cycle
RF_Address  output  ADDR_WIDTH  register-file address
RF_WrEn  output  1  one-cycle write strobe
RF_RdEn  output  1  one-cycle read strobe
RF_WrData  output  DATA_WIDTH  register-file write data
TX_P_DATA  output  DATA_WIDTH  byte to transmit; held stable from the strobe until TX_BUSY falls
TX_D_VLD  output  1  one-cycle transmit request
CMD_ERR  output  1  one-cycle pulse on an unknown command byte
OVR_ERR  output  1  one-cycle pulse when a byte arrives in a state that cannot accept it

Behaviour:
- Reset: all outputs are 0 and the FSM goes to IDLE, asynchronously on RST rising and held while RST is high. Reset mid-frame abandons the frame; no strobe is issued.
- All outputs are registered.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND, TX_HOLD.
- IDLE:
  - RX_D_VLD with WR_CMD -> WR_ADDR.
  - RX_D_VLD with RD_CMD -> RD_ADDR.
  - RX_D_VLD with any other byte -> CMD_ERR pulse the next cycle; stay in IDLE.
- WR_ADDR: on RX_D_VLD, latch RX_P_DATA[ADDR_WIDTH-1:0] into RF_Address; upper bits are ignored -> WR_DATA.
- WR_DATA: on RX_D_VLD, RF_WrData = byte and RF_WrEn = 1 for exactly one cycle, both in the cycle after the strobe -> IDLE.
- RD_ADDR: on RX_D_VLD, latch the address; RF_RdEn = 1 for one cycle (cycle after the strobe); clear the timeout counter -> RD_WAIT.
- RD_WAIT:
  - Counter increments each cycle.
  - RF_RdData_VLD -> latch RF_RdData into TX_P_DATA -> TX_SEND.
  - Counter reaches RD_TIMEOUT without VLD -> TX_P_DATA = TO_CODE -> TX_SEND.
  - VLD arriving in the same cycle the counter reaches RD_TIMEOUT: data wins.
  - RF_RdData_VLD outside RD_WAIT is ignored.
- TX_SEND: when TX_BUSY = 0, assert TX_D_VLD for one cycle -> TX_HOLD. While TX_BUSY = 1, wait with no time limit.
- TX_HOLD: wait for TX_BUSY to rise, then fall -> IDLE. If TX_BUSY has not risen within 2 cycles of TX_D_VLD, return to IDLE anyway; this covers a transmitter that already finished.
- RX_D_VLD in RD_WAIT, TX_SEND or TX_HOLD: byte is dropped; OVR_ERR pulses the next cycle; state is unchanged.
- Frames with no inter-byte gap (RX_D_VLD on consecutive cycles) are accepted in every state that expects a byte.
- RF_RdEn and RF_WrEn are never high in the same cycle. Each is at most one cycle per frame.
- RF_Address holds its last value between frames.

Test Plan:
- Write frame: RX bytes AA, 05, 3C -> single RF_WrEn cycle with RF_Address = 5 and RF_WrData = 3C; no TX_D_VLD; FSM back in IDLE.
- Read frame: RX bytes BB, 0A; RF answers with 0x5A two cycles after RF_RdEn; TX_BUSY stays high for 10 cycles after TX_D_VLD -> RF_RdEn once with address A; one TX_D_VLD with TX_P_DATA = 5A, stable until TX_BUSY falls.
- Read timeout: BB, 03 with no RF_RdData_VLD -> TX_D_VLD with TX_P_DATA = FF exactly RD_TIMEOUT cycles after RD_WAIT entry (+1 cycle for registering).
- Unknown command: byte 12 in IDLE -> CMD_ERR pulses for 1 cycle; then AA, 01, 77 -> normal write to address 1.
- Overrun and busy: TX_BUSY held high, read frame completes, byte 99 arrives during TX_SEND -> OVR_ERR pulse; TX_D_VLD is withheld until TX_BUSY is low.
- Reset mid-frame: RST asserted after AA, 02 -> all outputs 0 immediately; next frame AA, 04, 11 -> write to address 4 only.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// UART command-frame controller: decodes write/read frames from the RX byte stream into
// register-file accesses and returns read data (or a timeout code) to the transmitter.
module uart_cmd_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
  parameter int                    RD_TIMEOUT = 15,
  parameter logic [DATA_WIDTH-1:0] TO_CODE    = 8'hFF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  TX_BUSY,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  input  logic                  RF_RdData_VLD,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR,
  output logic                  OVR_ERR
);

  localparam int               CNT_W    = $clog2(RD_TIMEOUT + 1);
  // Timeout fires on the cycle the counter would step onto RD_TIMEOUT, so the reply
  // strobe lands RD_TIMEOUT cycles after entering RD_WAIT plus one register stage.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5,
    TX_HOLD = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            hold_cnt_q, hold_cnt_d;
  logic                  busy_seen_q, busy_seen_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  ovr_err_q, ovr_err_d;

  // Next-state and next-output decode for the frame FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    tx_data_d   = tx_data_q;
    cnt_d       = cnt_q;
    hold_cnt_d  = hold_cnt_q;
    busy_seen_d = busy_seen_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    tx_vld_d    = 1'b0;
    cmd_err_d   = 1'b0;
    ovr_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            state_d = WR_ADDR;
          end else if (RX_P_DATA == RD_CMD) begin
            state_d = RD_ADDR;
          end else begin
            cmd_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end else begin
          state_d = WR_ADDR;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = WR_DATA;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          cnt_d   = '0;
          state_d = RD_WAIT;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_WAIT: begin
        ovr_err_d = RX_D_VLD;
        if (RF_RdData_VLD) begin
          tx_data_d = RF_RdData;
          state_d   = TX_SEND;
        end else if (cnt_q == CNT_LAST) begin
          tx_data_d = TO_CODE;
          state_d   = TX_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_SEND: begin
        ovr_err_d = RX_D_VLD;
        if (!TX_BUSY) begin
          tx_vld_d    = 1'b1;
          hold_cnt_d  = 2'd0;
          busy_seen_d = 1'b0;
          state_d     = TX_HOLD;
        end else begin
          state_d = TX_SEND;
        end
      end
      TX_HOLD: begin
        ovr_err_d = RX_D_VLD;
        // A transmitter that never raises BUSY within the window is treated as already done.
        if (TX_BUSY) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          state_d = IDLE;
        end else if (hold_cnt_q == 2'd2) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_data_q   <= '0;
      tx_data_q   <= '0;
      cnt_q       <= '0;
      hold_cnt_q  <= 2'd0;
      busy_seen_q <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      tx_vld_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      ovr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      tx_data_q   <= tx_data_d;
      cnt_q       <= cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      busy_seen_q <= busy_seen_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      tx_vld_q    <= tx_vld_d;
      cmd_err_q   <= cmd_err_d;
      ovr_err_q   <= ovr_err_d;
    end
  end

  assign RF_Address = addr_q;
  assign RF_WrEn    = wr_en_q;
  assign RF_RdEn    = rd_en_q;
  assign RF_WrData  = wr_data_q;
  assign TX_P_DATA  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign CMD_ERR    = cmd_err_q;
  assign OVR_ERR    = ovr_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected strobe events (with the
// expected cycle), a negedge monitor pops and compares each strobe the DUT presents.
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic       busy_force = 1'b0;
  logic       busy_tx = 1'b0;
  logic       TX_BUSY;
  logic [7:0] RF_RdData = 8'h00;
  logic       RF_RdData_VLD = 1'b0;
  logic [3:0] RF_Address;
  logic       RF_WrEn;
  logic       RF_RdEn;
  logic [7:0] RF_WrData;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       CMD_ERR;
  logic       OVR_ERR;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         rf_delay = 0;
  logic [7:0] rf_data = 8'h00;
  logic [7:0] exp_tx = 8'h00;
  bit         tx_model_en = 1'b1;

  typedef enum logic [2:0] {EV_WR, EV_RD, EV_TX, EV_CMD, EV_OVR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] a;
    logic [7:0] d;
    int         cyc;
    string      tag;
  } ev_t;
  ev_t sb_q[$];

  assign TX_BUSY = busy_force | busy_tx;

  uart_cmd_ctrl dut (
    .CLK          (clk),
    .RST          (RST),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .TX_BUSY      (TX_BUSY),
    .RF_RdData    (RF_RdData),
    .RF_RdData_VLD(RF_RdData_VLD),
    .RF_Address   (RF_Address),
    .RF_WrEn      (RF_WrEn),
    .RF_RdEn      (RF_RdEn),
    .RF_WrData    (RF_WrData),
    .TX_P_DATA    (TX_P_DATA),
    .TX_D_VLD     (TX_D_VLD),
    .CMD_ERR      (CMD_ERR),
    .OVR_ERR      (OVR_ERR)
  );

  always #5 clk = ~clk;

  function automatic int cur();
    return cyc + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick(1);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic push(input ev_kind_e k, input logic [7:0] a, input logic [7:0] d,
                      input int c, input string tag);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    e.cyc  = c;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", n, act, exp);
    end
  endtask

  task automatic drain(input string n);
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < 200) begin
      tick(1);
      i++;
    end
    chk({n, "_all_events_seen"}, sb_q.size(), 32'd0);
    sb_q.delete();
    tick(14);
  endtask

  task automatic mon_cmp(input ev_kind_e k, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: got a=%h d=%h at cycle %0d, required no event",
               k.name(), a, d, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != k || e.a != a || e.d != d || (e.cyc >= 0 && e.cyc != cyc)) begin
        failures++;
        $display("FAIL %s: got %s a=%h d=%h cycle=%0d, required %s a=%h d=%h cycle=%0d",
                 e.tag, k.name(), a, d, cyc, e.kind.name(), e.a, e.d, e.cyc);
      end
    end
  endtask

  // Monitor: every strobe the DUT raises must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (RF_WrEn && RF_RdEn) begin
      checks++;
      failures++;
      $display("FAIL rd_wr_overlap: got both strobes at cycle %0d, required at most one", cyc);
    end
    if (RF_WrEn)  mon_cmp(EV_WR, {4'h0, RF_Address}, RF_WrData);
    if (RF_RdEn)  mon_cmp(EV_RD, {4'h0, RF_Address}, 8'h00);
    if (TX_D_VLD) mon_cmp(EV_TX, 8'h00, TX_P_DATA);
    if (CMD_ERR)  mon_cmp(EV_CMD, 8'h00, 8'h00);
    if (OVR_ERR)  mon_cmp(EV_OVR, 8'h00, 8'h00);
  end

  // Register-file model: answers a read strobe after rf_delay cycles (0 = never).
  initial forever begin
    @(negedge clk);
    if (RF_RdEn && rf_delay > 0) begin
      repeat (rf_delay) @(posedge clk);
      #1;
      RF_RdData     = rf_data;
      RF_RdData_VLD = 1'b1;
      @(posedge clk);
      #1;
      RF_RdData_VLD = 1'b0;
    end
  end

  // Transmitter model: BUSY for 10 cycles after a request; data must stay put meanwhile.
  initial forever begin
    @(negedge clk);
    if (TX_D_VLD && tx_model_en) begin
      @(posedge clk);
      #1;
      busy_tx = 1'b1;
      repeat (10) begin
        @(negedge clk);
        chk("tx_data_stable_while_busy", {24'h0, TX_P_DATA}, {24'h0, exp_tx});
      end
      @(posedge clk);
      #1;
      busy_tx = 1'b0;
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    RST = 1'b1;
    tick(3);
    chk("reset_outputs_zero", {7'h0, RF_Address, RF_WrEn, RF_RdEn, RF_WrData, TX_P_DATA,
                               TX_D_VLD, CMD_ERR, OVR_ERR}, 32'd0);
    RST = 1'b0;
    tick(2);

    // Back-to-back write frame.
    c = cur();
    push(EV_WR, 8'h05, 8'h3C, c + 3, "write_b2b");
    send(8'hAA); send(8'h05); send(8'h3C);
    drain("write_b2b");

    // Write with gaps between bytes; upper address bits ignored.
    c = cur();
    push(EV_WR, 8'h03, 8'hC5, c + 6, "write_gap_addr_mask");
    send(8'hAA); tick(2); send(8'hE3); tick(1); send(8'hC5);
    drain("write_gap");

    // Read with RF answering two cycles after RF_RdEn.
    rf_delay = 2; rf_data = 8'h5A; exp_tx = 8'h5A;
    c = cur();
    push(EV_RD, 8'h0A, 8'h00, c + 2, "read_rden");
    push(EV_TX, 8'h00, 8'h5A, c + 6, "read_tx");
    send(8'hBB); send(8'h0A);
    drain("read");

    // Read timeout: no RF answer.
    rf_delay = 0; exp_tx = 8'hFF;
    c = cur();
    push(EV_RD, 8'h03, 8'h00, c + 2, "timeout_rden");
    push(EV_TX, 8'h00, 8'hFF, c + 18, "timeout_tx");
    send(8'hBB); send(8'h03);
    drain("timeout");

    // Data arriving on the last wait cycle wins over the timeout.
    rf_delay = 14; rf_data = 8'hC3; exp_tx = 8'hC3;
    c = cur();
    push(EV_RD, 8'h06, 8'h00, c + 2, "last_cycle_rden");
    push(EV_TX, 8'h00, 8'hC3, c + 18, "last_cycle_data_wins");
    send(8'hBB); send(8'h06);
    drain("last_cycle");

    // Data one cycle too late: timeout code goes out, late strobe ignored.
    rf_delay = 15; rf_data = 8'h3C; exp_tx = 8'hFF;
    c = cur();
    push(EV_RD, 8'h08, 8'h00, c + 2, "late_rden");
    push(EV_TX, 8'h00, 8'hFF, c + 18, "late_data_timeout");
    send(8'hBB); send(8'h08);
    drain("late");

    // Unknown command, then a normal write.
    c = cur();
    push(EV_CMD, 8'h00, 8'h00, c + 1, "cmd_err");
    push(EV_WR, 8'h01, 8'h77, c + 5, "write_after_cmd_err");
    send(8'h12); tick(1); send(8'hAA); send(8'h01); send(8'h77);
    drain("cmd_err");

    // Overrun while waiting on a busy transmitter; TX_D_VLD withheld until BUSY drops.
    busy_force = 1'b1; rf_delay = 2; rf_data = 8'h42; exp_tx = 8'h42;
    c = cur();
    push(EV_RD, 8'h07, 8'h00, c + 2, "ovr_rden");
    send(8'hBB); send(8'h07);
    tick(4);
    push(EV_OVR, 8'h00, 8'h00, cur() + 1, "ovr_err");
    send(8'h99);
    tick(3);
    push(EV_TX, 8'h00, 8'h42, cur() + 1, "tx_after_busy");
    busy_force = 1'b0;
    drain("overrun");

    // Transmitter that never raises BUSY: controller must fall back to IDLE.
    tx_model_en = 1'b0; rf_delay = 2; rf_data = 8'h66;
    c = cur();
    push(EV_RD, 8'h02, 8'h00, c + 2, "nobusy_rden");
    push(EV_TX, 8'h00, 8'h66, c + 6, "nobusy_tx");
    send(8'hBB); send(8'h02);
    drain("nobusy");
    c = cur();
    push(EV_WR, 8'h09, 8'h5B, c + 3, "write_after_nobusy");
    send(8'hAA); send(8'h09); send(8'h5B);
    drain("write_after_nobusy");
    tx_model_en = 1'b1;

    // Reset mid-frame abandons it.
    send(8'hAA); send(8'h02);
    RST = 1'b1;
    #1;
    chk("midframe_reset_zero", {7'h0, RF_Address, RF_WrEn, RF_RdEn, RF_WrData, TX_P_DATA,
                                TX_D_VLD, CMD_ERR, OVR_ERR}, 32'd0);
    tick(2);
    RST = 1'b0;
    tick(1);
    c = cur();
    push(EV_WR, 8'h04, 8'h11, c + 3, "write_after_reset");
    send(8'hAA); send(8'h04); send(8'h11);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
